// File: rtl/tick_sched_pkg.sv
// Package for tick_rr_sched: FSM state type, idle-counter width and the id-width helper.
// Shared by the interface, the round-robin picker and the top.
package tick_sched_pkg;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned IDLE_CNT_W = 16;

  // Width of a requester index; never below 1 bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_rr_sched_if.sv
// Interface bundling the tick scheduler's control, config and grant signals.
// Ports (seen from the scheduler, modport slave):
//   en         in   run/stop level for the tick counter
//   cfg_valid  in   new period offered
//   cfg_period in   new period P (tick every P+1 cycles)
//   cfg_ready  out  period accepted when cfg_valid & cfg_ready
//   req        in   per-requester level requests
//   tick       out  combinational tick strobe
//   gnt        out  registered one-hot grant pulse
//   gnt_vld    out  registered, |gnt
//   gnt_id     out  registered index of the granted requester
//   busy       out  registered run indication
//   idle_cnt   out  idle-tick counter (only with TICK_SCHED_IDLE_CNT_EN)
// Modport master is the requester/configuration side.
interface tick_rr_sched_if
  import tick_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = 8
) ();

  localparam int unsigned ID_W = id_w(N_REQ);

  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_period;
  logic             cfg_ready;
  logic [N_REQ-1:0] req;
  logic             tick;
  logic [N_REQ-1:0] gnt;
  logic             gnt_vld;
  logic [ID_W-1:0]  gnt_id;
  logic             busy;
`ifdef TICK_SCHED_IDLE_CNT_EN
  logic [IDLE_CNT_W-1:0] idle_cnt;

  modport master (
    output en, cfg_valid, cfg_period, req,
    input  cfg_ready, tick, gnt, gnt_vld, gnt_id, busy, idle_cnt
  );

  modport slave (
    input  en, cfg_valid, cfg_period, req,
    output cfg_ready, tick, gnt, gnt_vld, gnt_id, busy, idle_cnt
  );
`else
  modport master (
    output en, cfg_valid, cfg_period, req,
    input  cfg_ready, tick, gnt, gnt_vld, gnt_id, busy
  );

  modport slave (
    input  en, cfg_valid, cfg_period, req,
    output cfg_ready, tick, gnt, gnt_vld, gnt_id, busy
  );
`endif

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at index ptr, wrapping modulo N_REQ, and returns the
// first set bit.
// Ports:
//   req     in   N_REQ  request vector
//   ptr     in   ID_W   index with highest priority (0..N_REQ-1)
//   onehot  out  N_REQ  one-hot of the chosen requester (0 when none)
//   id      out  ID_W   index of the chosen requester (0 when none)
//   any     out  1      some request was set
module rr_pick
  import tick_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [ID_W-1:0]  id,
  output logic             any
);

  always_comb begin
    logic [ID_W-1:0] idx;
    idx    = '0;
    onehot = '0;
    id     = '0;
    any    = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = ID_W'((32'(ptr) + i) % N_REQ);
      if (!any && req[idx]) begin
        any         = 1'b1;
        onehot[idx] = 1'b1;
        id          = idx;
      end
    end
  end

endmodule

// File: rtl/tick_rr_sched.sv
// Periodic tick generator with round-robin sharing of each tick among N_REQ
// requesters (at most one grant per tick), plus the period load handshake.
// Optional feature macro: TICK_SCHED_IDLE_CNT_EN adds bus.idle_cnt, a saturating
// count of ticks that found no request (cleared on a config accept).
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   bus  tick_rr_sched_if.slave: en, cfg_valid/cfg_period/cfg_ready, req, tick,
//        gnt, gnt_vld, gnt_id, busy (and idle_cnt when enabled)
module tick_rr_sched
  import tick_sched_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned PERIOD_RST = 3
) (
  input logic            clk,
  input logic            rst,
  tick_rr_sched_if.slave bus
);

  localparam int unsigned ID_W = id_w(N_REQ);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cur_period;
  logic [ID_W-1:0]  rr_ptr;

  logic             tick_int;
  logic             cfg_ready_int;
  logic             cfg_acc;
  logic             grant_ok;
  logic [N_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]  pick_id;
  logic             pick_any;
  logic [ID_W-1:0]  next_ptr;

  assign tick_int      = (state == ST_RUN) && (cnt == cur_period);
  // Running: a new period is only taken at a period boundary.
  assign cfg_ready_int = (state == ST_STOP) || tick_int;
  assign cfg_acc       = bus.cfg_valid && cfg_ready_int;
  // The edge that stops the counter never grants, even on a tick.
  assign grant_ok      = tick_int && bus.en;

  assign bus.tick      = tick_int;
  assign bus.cfg_ready = cfg_ready_int;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (bus.req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .id     (pick_id),
    .any    (pick_any)
  );

  assign next_ptr = (pick_id == ID_W'(N_REQ - 1)) ? '0 : pick_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_STOP;
      cnt         <= '0;
      cur_period  <= CNT_W'(PERIOD_RST);
      rr_ptr      <= '0;
      bus.gnt     <= '0;
      bus.gnt_vld <= 1'b0;
      bus.gnt_id  <= '0;
      bus.busy    <= 1'b0;
    end else begin
      // busy follows the state with one cycle of lag.
      bus.busy    <= (state == ST_RUN);
      bus.gnt     <= '0;
      bus.gnt_vld <= 1'b0;
      bus.gnt_id  <= '0;

      if (grant_ok && pick_any) begin
        bus.gnt     <= pick_onehot;
        bus.gnt_vld <= 1'b1;
        bus.gnt_id  <= pick_id;
        rr_ptr      <= next_ptr;
      end

      unique case (state)
        ST_STOP: begin
          cnt <= '0;
          if (bus.en) state <= ST_RUN;
        end
        ST_RUN: begin
          if (!bus.en) begin
            state <= ST_STOP;
            cnt   <= '0;
          end else if (tick_int) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase

      // A load restarts the period from zero; overrides the counter update above.
      if (cfg_acc) begin
        cur_period <= bus.cfg_period;
        cnt        <= '0;
      end
    end
  end

`ifdef TICK_SCHED_IDLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.idle_cnt <= '0;
    end else if (cfg_acc) begin
      bus.idle_cnt <= '0;
    end else if (grant_ok && (bus.req == '0) && (bus.idle_cnt != '1)) begin
      bus.idle_cnt <= bus.idle_cnt + IDLE_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_tick_rr_sched.sv
// Testbench for tick_rr_sched: cycle table for the basic run from reset,
// hand-written sequences for the multi-cycle corners, and a grant scoreboard.
module tb_tick_rr_sched;
  import tick_sched_pkg::*;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned CNT_W = 8;
  localparam int          NVEC  = 22;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tick_rr_sched_if #(.N_REQ(N_REQ), .CNT_W(CNT_W)) bus ();

  tick_rr_sched #(
    .N_REQ      (N_REQ),
    .CNT_W      (CNT_W),
    .PERIOD_RST (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
  } exp_t;

  exp_t sb[$];

  task automatic push(input logic [3:0] g, input logic [1:0] i);
    exp_t e;
    e.gnt = g;
    e.id  = i;
    sb.push_back(e);
  endtask

  // Every grant pulse must match the next expected grant, in order.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.gnt_vld || bus.gnt != '0)) begin
      if (sb.size() == 0) begin
        check("unexpected_gnt", 32'(bus.gnt), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_gnt", 32'(bus.gnt), 32'(e.gnt));
        check("sb_gnt_id", 32'(bus.gnt_id), 32'(e.id));
        check("sb_gnt_vld", 32'(bus.gnt_vld), 32'd1);
      end
    end
  end

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic       tick;
    logic       cfg_ready;
    logic       busy;
    logic [3:0] gnt;
  } vec_t;

  vec_t vecs[NVEC];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance until tick is seen within the current cycle, bounded by budget.
  task automatic wait_tick(input string name, input int budget);
    int n;
    n = 0;
    #1;
    while (!bus.tick && n < budget) begin
      cyc();
      #1;
      n++;
    end
    if (!bus.tick) check({name, "_tick_timeout"}, 32'(bus.tick), 32'd1);
  endtask

  initial begin
    rst            = 1'b1;
    bus.en         = 1'b0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_period = '0;
    bus.req        = '0;

    // Run from reset with all four requesting, period 3: tick every 4th cycle,
    // grant one cycle later, rotating 0,1,2,3,0.
    for (int i = 0; i < NVEC; i++) begin
      vecs[i].en        = 1'b1;
      vecs[i].req       = 4'hF;
      vecs[i].tick      = (i >= 4) && (i % 4 == 0);
      vecs[i].cfg_ready = (i == 0) || vecs[i].tick;
      vecs[i].busy      = (i >= 2);
      vecs[i].gnt       = ((i >= 5) && (i % 4 == 1)) ? (4'b0001 << (((i - 5) / 4) % 4)) : 4'b0000;
    end

    repeat (3) cyc();
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_gnt_vld", 32'(bus.gnt_vld), 32'd0);
    check("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
    check("rst_tick", 32'(bus.tick), 32'd0);
    check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
`ifdef TICK_SCHED_IDLE_CNT_EN
    check("rst_idle_cnt", 32'(bus.idle_cnt), 32'd0);
`endif
    rst = 1'b0;

    push(4'b0001, 2'd0);
    push(4'b0010, 2'd1);
    push(4'b0100, 2'd2);
    push(4'b1000, 2'd3);
    push(4'b0001, 2'd0);
    for (int i = 0; i < NVEC; i++) begin
      if (i > 0) cyc();
      bus.en  = vecs[i].en;
      bus.req = vecs[i].req;
      #1;
      check($sformatf("vec%0d_tick", i), 32'(bus.tick), 32'(vecs[i].tick));
      check($sformatf("vec%0d_cfg_ready", i), 32'(bus.cfg_ready), 32'(vecs[i].cfg_ready));
      check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_gnt", i), 32'(bus.gnt), 32'(vecs[i].gnt));
    end

    // Only requester 2: pointer 1 -> id 2, then pointer 3 -> still id 2.
    cyc();
    bus.req = 4'b0100;
    push(4'b0100, 2'd2);
    wait_tick("s2a", 8);
    cyc();
    #1;
    check("s2_gnt_id_a", 32'(bus.gnt_id), 32'd2);
    check("s2_gnt_vld_a", 32'(bus.gnt_vld), 32'd1);
    push(4'b0100, 2'd2);
    wait_tick("s2b", 8);
    cyc();
    #1;
    check("s2_gnt_id_b", 32'(bus.gnt_id), 32'd2);
    // Pointer now 3: with everyone requesting, 3 wins.
    bus.req = 4'hF;
    push(4'b1000, 2'd3);
    wait_tick("s2c", 8);
    cyc();
    #1;
    check("s2_ptr3_gnt", 32'(bus.gnt), 32'b1000);

    // Period change while running: ready only on the tick, then period 2 cycles.
    bus.req        = 4'b0000;
    bus.cfg_valid  = 1'b1;
    bus.cfg_period = 8'd1;
    #1;
    check("s3_cfg_ready_mid", 32'(bus.cfg_ready), 32'd0);
    wait_tick("s3", 8);
    check("s3_cfg_ready_tick", 32'(bus.cfg_ready), 32'd1);
    cyc();
    bus.cfg_valid = 1'b0;
    #1;
    check("s3_tick_c0", 32'(bus.tick), 32'd0);
    cyc();
    #1;
    check("s3_tick_c1", 32'(bus.tick), 32'd1);
    cyc();
    #1;
    check("s3_tick_c2", 32'(bus.tick), 32'd0);
    cyc();
    #1;
    check("s3_tick_c3", 32'(bus.tick), 32'd1);

    // Drop en on a tick cycle: no grant, busy falls a cycle later, restart at cnt 0.
    cyc();
    bus.req = 4'b0001;
    wait_tick("s4", 4);
    bus.en = 1'b0;
    cyc();
    #1;
    check("s4_gnt_after_stop", 32'(bus.gnt), 32'd0);
    check("s4_busy_lag", 32'(bus.busy), 32'd1);
    check("s4_tick_stopped", 32'(bus.tick), 32'd0);
    check("s4_cfg_ready_stopped", 32'(bus.cfg_ready), 32'd1);
    cyc();
    #1;
    check("s4_busy_low", 32'(bus.busy), 32'd0);
    bus.en = 1'b1;
    push(4'b0001, 2'd0);
    cyc();
    #1;
    check("s4_restart_c0", 32'(bus.tick), 32'd0);
    cyc();
    #1;
    check("s4_restart_c1", 32'(bus.tick), 32'd1);
    cyc();
    #1;
    check("s4_restart_gnt", 32'(bus.gnt), 32'b0001);

    // Period 0 loaded with en rising: tick every cycle, back-to-back grants 1,0,1,0.
    bus.en  = 1'b0;
    bus.req = 4'b0000;
    cyc();
    bus.en         = 1'b1;
    bus.cfg_valid  = 1'b1;
    bus.cfg_period = 8'd0;
    bus.req        = 4'b0011;
    push(4'b0010, 2'd1);
    push(4'b0001, 2'd0);
    push(4'b0010, 2'd1);
    push(4'b0001, 2'd0);
    cyc();
    bus.cfg_valid = 1'b0;
    #1;
    check("s5_tick_first", 32'(bus.tick), 32'd1);
    check("s5_gnt_first", 32'(bus.gnt), 32'd0);
    cyc();
    #1;
    check("s5_gnt_a", 32'(bus.gnt), 32'b0010);
    cyc();
    #1;
    check("s5_gnt_b", 32'(bus.gnt), 32'b0001);
    cyc();
    #1;
    check("s5_gnt_c", 32'(bus.gnt), 32'b0010);
    check("s5_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    cyc();
    #1;
    check("s5_gnt_d", 32'(bus.gnt), 32'b0001);
    bus.req = 4'b0000;
    cyc();
    #1;
    check("s5_gnt_none", 32'(bus.gnt), 32'd0);

`ifdef TICK_SCHED_IDLE_CNT_EN
    // Clear via a config accept, then count five empty ticks.
    bus.cfg_valid  = 1'b1;
    bus.cfg_period = 8'd0;
    cyc();
    bus.cfg_valid = 1'b0;
    #1;
    check("idle_cleared", 32'(bus.idle_cnt), 32'd0);
    repeat (5) cyc();
    #1;
    check("idle_five", 32'(bus.idle_cnt), 32'd5);
`endif

    // Reset on a tick with requests pending: no grant, everything back to reset.
    bus.req = 4'b0011;
    rst     = 1'b1;
    cyc();
    #1;
    check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_tick", 32'(bus.tick), 32'd0);
    check("mid_rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
`ifdef TICK_SCHED_IDLE_CNT_EN
    check("mid_rst_idle_cnt", 32'(bus.idle_cnt), 32'd0);
`endif
    rst     = 1'b0;
    bus.req = 4'hF;
    push(4'b0001, 2'd0);
    cyc();
    #1;
    check("post_rst_c0", 32'(bus.tick), 32'd0);
    cyc();
    cyc();
    cyc();
    #1;
    check("post_rst_tick_p3", 32'(bus.tick), 32'd1);
    cyc();
    #1;
    check("post_rst_gnt", 32'(bus.gnt), 32'b0001);

    bus.en  = 1'b0;
    bus.req = 4'b0000;
    repeat (3) cyc();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
